freq_counter: RTL and testbench

- Gated edge counter that measures the frequency of an external digital signal.
- Produces the 14-bit frequency word f that the corner-frequency state look-up consumes.
- Each measurement window is exactly GATE_CYCLES clk cycles. The rising-edge count of the window is published with a one-cycle valid strobe.
- Also flags counter saturation and loss of signal, so the control logic can hold its last state instead of acting on garbage.

---
 rtl/freq_counter.sv | 145 ++++++++++++++
 tb/tb_freq_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter.sv
// freq_counter
//   Gated rising-edge counter. It measures the frequency of an asynchronous
//   digital input over fixed windows of GATE_CYCLES clk cycles. At the end of
//   each window it publishes the saturated edge count. It also reports counter
//   saturation and a loss-of-signal condition, so that downstream control can
//   hold its last state.
//
// Parameters
//   F_W         : width of f and of the edge counter
//   GATE_CYCLES : window length in clk cycles (2 .. 2^24-1)
//   LOST_GATES  : consecutive zero-count windows needed to raise sig_lost (1 .. 255)
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : measurement enable (level, synchronous to clk)
//   sig_in   : measured signal, asynchronous to clk
//   f        : edge count of the last completed window, saturated
//   f_valid  : one-cycle strobe when f / ovf / sig_lost update
//   ovf      : the last completed window saturated
//   sig_lost : LOST_GATES or more consecutive windows had no edges
module freq_counter #(
   parameter int F_W         = 14,
   parameter int GATE_CYCLES = 50000,
   parameter int LOST_GATES  = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           sig_in,
   output logic [F_W-1:0] f,
   output logic           f_valid,
   output logic           ovf,
   output logic           sig_lost
);

   localparam int                GCNT_W    = 24;
   localparam logic [GCNT_W-1:0] GATE_LAST = GCNT_W'(GATE_CYCLES - 1);
   localparam logic [F_W-1:0]    CNT_MAX   = '1;
   localparam logic [8:0]        LOST_LIM  = 9'(LOST_GATES);

   // sync_reg[0] = s1, sync_reg[1] = s2, sync_reg[2] = s3
   logic [2:0]        sync_reg;
   logic              rise;

   logic [GCNT_W-1:0] gcnt_reg, gcnt_next;
   logic [F_W-1:0]    cnt_reg, cnt_next;
   logic              ovf_pend_reg, ovf_pend_next;
   logic [7:0]        zcnt_reg, zcnt_next;

   logic [F_W-1:0]    f_next;
   logic              f_valid_next;
   logic              ovf_next;
   logic              sig_lost_next;

   logic              cnt_full;
   logic [F_W-1:0]    close_cnt;
   logic              close_ovf;
   logic [8:0]        zcnt_inc;

   // The first two stages resolve metastability. The third stage exists only
   // to detect rising edges on the already-synchronised signal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[1:0], sig_in};
      end
   end

   assign rise = sync_reg[1] & ~sync_reg[2];

   // An edge in the closing cycle belongs to the closing window, so the
   // published count and overflow flag fold in the current edge.
   assign cnt_full  = (cnt_reg == CNT_MAX);
   assign close_cnt = (rise && !cnt_full) ? cnt_reg + F_W'(1) : cnt_reg;
   assign close_ovf = ovf_pend_reg | (cnt_full & rise);
   assign zcnt_inc  = {1'b0, zcnt_reg} + 9'd1;

   always_comb begin
      gcnt_next     = gcnt_reg;
      cnt_next      = cnt_reg;
      ovf_pend_next = ovf_pend_reg;
      zcnt_next     = zcnt_reg;
      f_next        = f;
      ovf_next      = ovf;
      sig_lost_next = sig_lost;
      f_valid_next  = 1'b0;

      if (!en) begin
         // A partial window is discarded. The published results hold.
         gcnt_next     = '0;
         cnt_next      = '0;
         ovf_pend_next = 1'b0;
      end else if (gcnt_reg == GATE_LAST) begin
         f_next        = close_cnt;
         ovf_next      = close_ovf;
         f_valid_next  = 1'b1;
         gcnt_next     = '0;
         cnt_next      = '0;
         ovf_pend_next = 1'b0;
         // A saturated window is never zero, so close_cnt alone decides
         // whether this window counts towards loss of signal.
         if (close_cnt == '0) begin
            zcnt_next     = (zcnt_inc >= LOST_LIM) ? LOST_LIM[7:0] : zcnt_inc[7:0];
            sig_lost_next = (zcnt_inc >= LOST_LIM);
         end else begin
            zcnt_next     = '0;
            sig_lost_next = 1'b0;
         end
      end else begin
         gcnt_next = gcnt_reg + 24'd1;
         if (rise) begin
            if (cnt_full) begin
               ovf_pend_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + F_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gcnt_reg     <= '0;
         cnt_reg      <= '0;
         ovf_pend_reg <= 1'b0;
         zcnt_reg     <= '0;
         f            <= '0;
         f_valid      <= 1'b0;
         ovf          <= 1'b0;
         sig_lost     <= 1'b0;
      end else begin
         gcnt_reg     <= gcnt_next;
         cnt_reg      <= cnt_next;
         ovf_pend_reg <= ovf_pend_next;
         zcnt_reg     <= zcnt_next;
         f            <= f_next;
         f_valid      <= f_valid_next;
         ovf          <= ovf_next;
         sig_lost     <= sig_lost_next;
      end
   end

endmodule

// File: tb/tb_freq_counter.sv
// tb_freq_counter
//   Bench for freq_counter (F_W=4, GATE_CYCLES=100, LOST_GATES=4).
//   A window-level reference model predicts each published result and queues
//   it. A monitor on the falling edge pops and compares those results whenever
//   f_valid is seen. Between strobes, the monitor checks that the outputs hold.
module tb_freq_counter;

   localparam int F_W  = 4;
   localparam int GATE = 100;
   localparam int LOST = 4;
   localparam int MAXC = (1 << F_W) - 1;

   logic           clk    = 1'b0;
   logic           rst    = 1'b1;
   logic           en     = 1'b0;
   logic           sig_in = 1'b0;
   logic [F_W-1:0] f;
   logic           f_valid;
   logic           ovf;
   logic           sig_lost;

   freq_counter #(
      .F_W        (F_W),
      .GATE_CYCLES(GATE),
      .LOST_GATES (LOST)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sig_in  (sig_in),
      .f       (f),
      .f_valid (f_valid),
      .ovf     (ovf),
      .sig_lost(sig_lost)
   );

   always #5 clk = ~clk;

   typedef struct {
      int f;
      bit ovf;
      bit lost;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // ---------------- stimulus generator (drives sig_in on falling edges)
   // mode 0: hold low; 1: square wave starting low; 2: random runs of >=2 cycles; 3: directed
   int mode     = 0;
   int period   = 10;
   int phase    = 0;
   int run_left = 0;

   task automatic set_mode(input int m, input int p);
      mode     = m;
      period   = p;
      phase    = 0;
      run_left = 0;
   endtask

   always @(negedge clk) begin
      case (mode)
         0: sig_in = 1'b0;
         1: begin
            sig_in = (phase >= period / 2);
            phase  = (phase + 1) % period;
         end
         2: begin
            if (run_left == 0) begin
               sig_in   = ~sig_in;
               run_left = $urandom_range(1, 5);
            end else begin
               run_left--;
            end
         end
         default: ;
      endcase
   end

   // ---------------- reference model
   // A rise of sig_in, as sampled on a clock edge, becomes visible two edges
   // later. Each window tallies the true number of edges. Saturation, overflow
   // and loss of signal are then derived from that tally.
   bit hist[$];
   bit rise_seen;
   int pos, wcnt, zero_run;
   int last_f;
   bit last_ovf, last_lost;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist      = '{1'b0, 1'b0, 1'b0};
         pos       = 0;
         wcnt      = 0;
         zero_run  = 0;
         last_f    = 0;
         last_ovf  = 1'b0;
         last_lost = 1'b0;
         exp_q.delete();
      end else begin
         rise_seen = hist[1] && !hist[0];
         void'(hist.pop_front());
         hist.push_back(sig_in);
         if (!en) begin
            pos  = 0;
            wcnt = 0;
         end else begin
            wcnt += int'(rise_seen);
            if (pos == GATE - 1) begin
               if (wcnt == 0) zero_run++;
               else           zero_run = 0;
               last_f    = (wcnt > MAXC) ? MAXC : wcnt;
               last_ovf  = (wcnt > MAXC);
               last_lost = (zero_run >= LOST);
               exp_q.push_back('{last_f, last_ovf, last_lost});
               pos  = 0;
               wcnt = 0;
            end else begin
               pos++;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard
   exp_t e;
   always @(negedge clk) begin
      if (!rst) begin
         if (f_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               $display("window t=%0t f=%0d ovf=%0b sig_lost=%0b (exp f=%0d ovf=%0b sig_lost=%0b)",
                        $time, f, ovf, sig_lost, e.f, e.ovf, e.lost);
               chk("win_f", int'(f), e.f);
               chk("win_ovf", int'(ovf), int'(e.ovf));
               chk("win_sig_lost", int'(sig_lost), int'(e.lost));
            end
         end else begin
            if (exp_q.size() != 0) begin
               chk("missing_valid", 0, 1);
               exp_q.delete();
            end
            chk("hold_outputs", {26'd0, ovf, sig_lost, f}, {26'd0, last_ovf, last_lost, 4'(last_f)});
         end
      end
   end

   // ---------------- sequence
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string name);
      chk({name, "_f"}, int'(f), 0);
      chk({name, "_f_valid"}, int'(f_valid), 0);
      chk({name, "_ovf"}, int'(ovf), 0);
      chk({name, "_sig_lost"}, int'(sig_lost), 0);
   endtask

   initial begin
      // Reset state.
      rst = 1'b1;
      cycles(3);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Square wave of period 10: 10 edges per window.
      set_mode(1, 10);
      en = 1'b1;
      cycles(450);

      // Saturation (25 edges), then recovery (5 edges).
      set_mode(1, 4);
      cycles(300);
      set_mode(1, 20);
      cycles(300);

      // Loss of signal over five quiet windows, then a single edge.
      set_mode(0, 0);
      cycles(520);
      set_mode(3, 0);
      sig_in = 1'b1;
      cycles(3);
      sig_in = 1'b0;
      cycles(200);

      // The window restarts, and the only edge lands in the closing cycle.
      en = 1'b0;
      cycles(1);
      en = 1'b1;
      cycles(97);
      sig_in = 1'b1;
      cycles(3);
      sig_in = 1'b0;
      cycles(250);

      // en dropped mid-window for 30 cycles.
      set_mode(1, 10);
      en = 1'b0;
      cycles(1);
      en = 1'b1;
      cycles(50);
      en = 1'b0;
      cycles(30);
      en = 1'b1;
      cycles(250);

      // Reset pulse mid-window: the outputs clear immediately.
      en = 1'b0;
      cycles(1);
      en = 1'b1;
      cycles(70);
      rst = 1'b1;
      #1;
      check_zero_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      cycles(250);

      // Randomised signal with occasional enable drops.
      set_mode(2, 0);
      for (int i = 0; i < 20; i++) begin
         cycles($urandom_range(20, 300));
         en = ($urandom_range(0, 4) != 0);
      end
      en = 1'b1;
      cycles(210);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
